// File: rtl/shift_rows_pipe_pkg.sv
// Shared AES definitions: state width, byte/row/column index helpers and the
// cipher direction encoding.
package shift_rows_pipe_pkg;

    localparam int unsigned STATE_W  = 128;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic {
        DEC = 1'b0,
        ENC = 1'b1
    } aes_mode_e;

    // Byte index within the state for row r, column c (column-major order).
    function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
        return NUM_ROWS * col + row;
    endfunction

    // Bit position of the least significant bit of byte idx; byte 0 sits at the MSBs.
    function automatic int unsigned byte_lsb(input int unsigned idx);
        return STATE_W - 8 - 8 * idx;
    endfunction

    // Source column feeding output column col of row row when encrypting.
    function automatic int unsigned enc_src_col(input int unsigned row, input int unsigned col);
        return (col + row) % NUM_COLS;
    endfunction

    // Source column feeding output column col of row row when decrypting.
    function automatic int unsigned dec_src_col(input int unsigned row, input int unsigned col);
        return (col + NUM_COLS - row) % NUM_COLS;
    endfunction

endpackage

// File: rtl/shift_rows_pipe_core.sv
// Combinational ShiftRows / InvShiftRows on one 128-bit AES state.
module shift_rows_core
    import shift_rows_pipe_pkg::*;
(
    input  logic               op_i,
    input  logic [STATE_W-1:0] data_i,
    output logic [STATE_W-1:0] data_o
);

    logic [STATE_W-1:0] enc_data;
    logic [STATE_W-1:0] dec_data;

    // Both byte permutations are pure wiring; the mode only selects between them.
    always_comb begin
        enc_data = '0;
        dec_data = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
                enc_data[byte_lsb(byte_idx(r, c)) +: 8] =
                    data_i[byte_lsb(byte_idx(r, enc_src_col(r, c))) +: 8];
                dec_data[byte_lsb(byte_idx(r, c)) +: 8] =
                    data_i[byte_lsb(byte_idx(r, dec_src_col(r, c))) +: 8];
            end
        end
    end

    assign data_o = (aes_mode_e'(op_i) == ENC) ? enc_data : dec_data;

endmodule

// File: rtl/shift_rows_pipe.sv
// Multi-lane ShiftRows/InvShiftRows with a STAGES-deep valid/ready pipeline,
// flush, and a free-running count of output handshakes.
module shift_rows_pipe
    import shift_rows_pipe_pkg::*;
#(
    parameter int unsigned LANES  = 1,
    parameter int unsigned STAGES = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      op_i,
    input  logic [STATE_W*LANES-1:0]  data_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      op_o,
    output logic [STATE_W*LANES-1:0]  data_o,
    output logic [15:0]               count_o,
    output logic                      busy_o
);

    localparam int unsigned DATA_W = STATE_W * LANES;

    logic [DATA_W-1:0] xform_data;

    logic              stage_valid [STAGES];
    logic              stage_op    [STAGES];
    logic [DATA_W-1:0] stage_data  [STAGES];
    logic              stage_rdy   [STAGES];
    logic              in_valid    [STAGES];
    logic              in_op       [STAGES];
    logic [DATA_W-1:0] in_data     [STAGES];

    logic [15:0] count_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        shift_rows_core u_core (
            .op_i   (op_i),
            .data_i (data_i[STATE_W*k +: STATE_W]),
            .data_o (xform_data[STATE_W*k +: STATE_W])
        );
    end

    // A stage can load when it is empty or its content moves on this cycle.
    always_comb begin
        logic rdy_chain;
        rdy_chain = ready_i;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            rdy_chain    = !stage_valid[s] || rdy_chain;
            stage_rdy[s] = rdy_chain;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic              valid_q;
        logic              op_q;
        logic [DATA_W-1:0] data_q;

        if (s == 0) begin : g_head
            // Transform happens before the first register; later stages only carry.
            assign in_valid[s] = valid_i && !flush_i;
            assign in_op[s]    = op_i;
            assign in_data[s]  = xform_data;
        end else begin : g_body
            assign in_valid[s] = stage_valid[s-1];
            assign in_op[s]    = stage_op[s-1];
            assign in_data[s]  = stage_data[s-1];
        end

        // Occupancy: cleared by reset or flush, otherwise refreshed whenever the stage loads.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else if (stage_rdy[s]) begin
                valid_q <= in_valid[s];
            end
        end

        // Payload registers carry no reset; they only matter while valid_q is set.
        always_ff @(posedge clk_i) begin
            if (stage_rdy[s] && in_valid[s]) begin
                op_q   <= in_op[s];
                data_q <= in_data[s];
            end
        end

        assign stage_valid[s] = valid_q;
        assign stage_op[s]    = op_q;
        assign stage_data[s]  = data_q;
    end

    assign ready_o = rst_ni && !flush_i && stage_rdy[0];
    assign valid_o = stage_valid[STAGES-1];
    assign op_o    = stage_op[STAGES-1];
    assign data_o  = stage_data[STAGES-1];

    // Busy reflects registered occupancy only.
    always_comb begin
        busy_o = 1'b0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            busy_o = busy_o || stage_valid[s];
        end
    end

    // Output handshake counter; survives flush, wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (valid_o && ready_i) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed and randomised checks of shift_rows_pipe with LANES=4, STAGES=3.
module tb_shift_rows_pipe;

    localparam int unsigned LANES  = 4;
    localparam int unsigned STAGES = 3;
    localparam int unsigned W      = 128 * LANES;

    // Source byte for each output byte, read off the hand-worked reference vectors.
    localparam int ENC_SRC [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
    localparam int DEC_SRC [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          valid_i;
    logic          ready_o;
    logic          op_i;
    logic [W-1:0]  data_i;
    logic          valid_o;
    logic          ready_i;
    logic          op_o;
    logic [W-1:0]  data_o;
    logic [15:0]   count_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;

    logic [W:0]    exp_q [$];
    logic          hold_pend = 1'b0;
    logic [W+1:0]  held;
    logic          last_in_hs;
    int            in_cnt = 0;

    shift_rows_pipe #(
        .LANES  (LANES),
        .STAGES (STAGES)
    ) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .op_o    (op_o),
        .data_o  (data_o),
        .count_o (count_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_lane(input logic [127:0] x, input logic enc);
        logic [127:0] y;
        int src;
        for (int i = 0; i < 16; i++) begin
            src = enc ? ENC_SRC[i] : DEC_SRC[i];
            y[127-8*i -: 8] = x[127-8*src -: 8];
        end
        return y;
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] x, input logic enc);
        logic [W-1:0] y;
        for (int k = 0; k < int'(LANES); k++) begin
            y[128*k +: 128] = ref_lane(x[128*k +: 128], enc);
        end
        return y;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] v;
        for (int i = 0; i < int'(W / 32); i++) begin
            v[32*i +: 32] = $urandom;
        end
        return v;
    endfunction

    // One clock cycle with scoreboard bookkeeping and stall-stability checking.
    task automatic cyc(input logic v, input logic o, input logic [W-1:0] d, input logic r);
        if (hold_pend) begin
            check_eq("hold_stable", {valid_o, op_o, data_o}, held);
        end
        valid_i = v;
        op_i    = o;
        data_i  = d;
        ready_i = r;
        #1;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 1, 0);
            end else begin
                check_eq("beat", {1'b0, op_o, data_o}, {1'b0, exp_q.pop_front()});
            end
        end
        last_in_hs = valid_i && ready_o;
        if (last_in_hs) begin
            exp_q.push_back({o, ref_beat(d, o)});
            in_cnt++;
        end
        hold_pend = valid_o && !ready_i;
        held      = {valid_o, op_o, data_o};
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic o, input logic [127:0] din,
                            input logic [127:0] dexp);
        valid_i = 1'b1;
        op_i    = o;
        data_i  = {LANES{din}};
        ready_i = 1'b1;
        #1;
        check_eq({tag, "_ready"}, ready_o, 1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        for (int i = 1; i < int'(STAGES); i++) begin
            check_eq({tag, "_early"}, valid_o, 0);
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_valid"}, valid_o, 1);
        check_eq({tag, "_data"}, {op_o, data_o}, {o, {LANES{dexp}}});
        @(posedge clk);
        #1;
    endtask

    task automatic drop_state();
        exp_q.delete();
        hold_pend = 1'b0;
    endtask

    initial begin
        int sent;
        int cycles;
        logic stream_op;

        rst_n   = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        op_i    = 1'b1;
        data_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", ready_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_count", count_o, 0);
        valid_i = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        // Reference vectors, latency and round trip
        directed("enc", 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h00050a0f04090e03080d02070c01060b);
        directed("dec", 1'b0, 128'h000102030405060708090a0b0c0d0e0f,
                 128'h000d0a0704010e0b0805020f0c090603);
        directed("roundtrip", 1'b0, 128'h00050a0f04090e03080d02070c01060b,
                 128'h000102030405060708090a0b0c0d0e0f);
        check_eq("dir_count", count_o, 3);

        // Backpressure: ready_i low for 10 cycles, then drain
        in_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, i[0], rand_beat(), 1'b0);
        end
        check_eq("bp_accepted", in_cnt, STAGES);
        check_eq("bp_ready", ready_o, 0);
        check_eq("bp_busy", busy_o, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
        end
        check_eq("bp_drained", exp_q.size(), 0);
        check_eq("bp_count", count_o, 6);

        // Flush with three beats in flight: first with a concurrent output handshake, then without
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                cyc(1'b1, 1'b1, rand_beat(), 1'b0);
            end
            flush_i = 1'b1;
            valid_i = 1'b1;
            ready_i = (f == 0);
            #1;
            check_eq("flush_ready", ready_o, 0);
            check_eq("flush_valid", valid_o, 1);
            @(posedge clk);
            #1;
            flush_i = 1'b0;
            valid_i = 1'b0;
            drop_state();
            check_eq("flush_busy", busy_o, 0);
            check_eq("flush_vo", valid_o, 0);
            check_eq("flush_count", count_o, 7);
        end

        // Streaming: fresh reset, 1000 random beats, alternating op, random ready
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drop_state();
        sent      = 0;
        cycles    = 0;
        stream_op = 1'b1;
        while ((sent < 1000 || exp_q.size() > 0) && cycles < 20000) begin
            cyc((sent < 1000) && ($urandom_range(0, 3) != 0), stream_op, rand_beat(),
                $urandom_range(0, 2) != 0);
            if (last_in_hs) begin
                sent++;
                stream_op = !stream_op;
            end
            cycles++;
        end
        check_eq("stream_in_time", cycles < 20000, 1);
        check_eq("stream_empty", exp_q.size(), 0);
        check_eq("stream_count", count_o, 1000);

        // Reset mid-stream discards in-flight beats
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, rand_beat(), 1'b0);
        end
        rst_n   = 1'b0;
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1;
        check_eq("midrst_ready", ready_o, 0);
        @(posedge clk);
        #1;
        check_eq("midrst_valid", valid_o, 0);
        check_eq("midrst_busy", busy_o, 0);
        check_eq("midrst_count", count_o, 0);
        valid_i = 1'b0;
        rst_n   = 1'b1;
        drop_state();
        @(posedge clk);
        #1;
        check_eq("midrst_hold", valid_o, 0);

        // Wrap: 0xFFFE back-to-back beats (also proves one beat per cycle), then 2 more
        valid_i = 1'b1;
        ready_i = 1'b1;
        data_i  = '0;
        repeat (65534) @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (STAGES) @(posedge clk);
        #1;
        check_eq("wrap_pre", count_o, 16'hfffe);
        valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (STAGES) @(posedge clk);
        #1;
        check_eq("wrap_count", count_o, 16'h0000);
        check_eq("wrap_busy", busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
